// File: rtl/decode_stage_hz_if.sv
// Decode-to-execute bundle: D-side inputs, W-side write-back, registered E outputs.
interface decode_stage_hz_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      InstrD;
    logic [31:0]      PCD;
    logic [31:0]      PCPlus4D;
    logic             ValidD;
    logic             StallE;
    logic             FlushE;
    logic             RegWriteW;
    logic [4:0]       RDW;
    logic [31:0]      ResultW;

    logic             LoadUseD;
    logic             ValidE;
    logic             RegWriteE;
    logic             ALUSrcE;
    logic             MemWriteE;
    logic             ResultSrcE;
    logic             BranchE;
    logic             JumpE;
    logic [2:0]       ALUControlE;
    logic [31:0]      RD1_E;
    logic [31:0]      RD2_E;
    logic [31:0]      Imm_Ext_E;
    logic [31:0]      PCE;
    logic [31:0]      PCPlus4E;
    logic [4:0]       RS1_E;
    logic [4:0]       RS2_E;
    logic [4:0]       RD_E;
    logic             IllegalE;
    logic [CNT_W-1:0] BubbleCnt;

    modport master (
        output InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE,
        output RegWriteW, RDW, ResultW,
        input  LoadUseD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
        input  ResultSrcE, BranchE, JumpE, ALUControlE,
        input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        input  RS1_E, RS2_E, RD_E, IllegalE, BubbleCnt
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, ValidD, StallE, FlushE,
        input  RegWriteW, RDW, ResultW,
        output LoadUseD, ValidE, RegWriteE, ALUSrcE, MemWriteE,
        output ResultSrcE, BranchE, JumpE, ALUControlE,
        output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
        output RS1_E, RS2_E, RD_E, IllegalE, BubbleCnt
    );
endinterface

// File: rtl/decode_stage_hz.sv
// RV32I/E decode stage with register file, load-use hazard unit and ID/EX register.
module decode_stage_hz #(
    parameter int NREGS  = 32,
    parameter int BYPASS = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    decode_stage_hz_if.slave  dx
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [5:0] NR       = 6'(NREGS);

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        alusrc;
        logic        memwrite;
        logic        resultsrc;
        logic        branch;
        logic        jump;
        logic [2:0]  aluctl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } id_ex_t;

    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic             w_f7b5;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic [4:0]       w_rd;
    logic             w_is_ld;
    logic             w_is_st;
    logic             w_is_r;
    logic             w_is_br;
    logic             w_is_im;
    logic             w_is_jal;
    logic             w_regwrite;
    logic             w_alusrc;
    logic             w_memwrite;
    logic             w_resultsrc;
    logic             w_branch;
    logic             w_jump;
    logic [1:0]       w_immsrc;
    logic [1:0]       w_aluop;
    logic [2:0]       w_aluctl;
    logic [31:0]      w_imm;
    logic             w_we;
    logic [31:0]      w_rd1;
    logic [31:0]      w_rd2;
    logic             w_use1;
    logic             w_use2;
    logic             w_lu;
    id_ex_t           w_dec;

    logic [31:0]      r_regs [1:NREGS-1];
    id_ex_t           r_e;
    logic [CNT_W-1:0] r_bcnt;

    assign w_op   = dx.InstrD[6:0];
    assign w_rd   = dx.InstrD[11:7];
    assign w_f3   = dx.InstrD[14:12];
    assign w_rs1  = dx.InstrD[19:15];
    assign w_rs2  = dx.InstrD[24:20];
    assign w_f7b5 = dx.InstrD[30];

    assign w_is_ld  = (w_op == OP_LOAD);
    assign w_is_st  = (w_op == OP_STORE);
    assign w_is_r   = (w_op == OP_R);
    assign w_is_br  = (w_op == OP_BR);
    assign w_is_im  = (w_op == OP_IMM);
    assign w_is_jal = (w_op == OP_JAL);

    always_comb begin
        w_regwrite  = 1'b0;
        w_alusrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_resultsrc = 1'b0;
        w_branch    = 1'b0;
        w_jump      = 1'b0;
        w_immsrc    = 2'b00;
        w_aluop     = 2'b00;
        unique case (1'b1)
            w_is_ld: begin
                w_regwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_resultsrc = 1'b1;
            end
            w_is_st: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_immsrc   = 2'b01;
            end
            w_is_r: begin
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
            end
            w_is_br: begin
                w_branch = 1'b1;
                w_immsrc = 2'b10;
                w_aluop  = 2'b01;
            end
            w_is_im: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = 2'b10;
            end
            w_is_jal: begin
                w_regwrite = 1'b1;
                w_jump     = 1'b1;
                w_immsrc   = 2'b11;
            end
            default: ;
        endcase
    end

    // ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
    always_comb begin
        w_aluctl = 3'b000;
        unique case (w_aluop)
            2'b01: w_aluctl = 3'b001;
            2'b10: begin
                case (w_f3)
                    3'b000:  w_aluctl = (w_op[5] & w_f7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_aluctl = 3'b101;
                    3'b110:  w_aluctl = 3'b011;
                    3'b111:  w_aluctl = 3'b010;
                    default: w_aluctl = 3'b000;
                endcase
            end
            default: w_aluctl = 3'b000;
        endcase
    end

    always_comb begin
        w_imm = '0;
        unique case (w_immsrc)
            2'b00: w_imm = {{20{dx.InstrD[31]}}, dx.InstrD[31:20]};
            2'b01: w_imm = {{20{dx.InstrD[31]}}, dx.InstrD[31:25],
                            dx.InstrD[11:7]};
            2'b10: w_imm = {{20{dx.InstrD[31]}}, dx.InstrD[7],
                            dx.InstrD[30:25], dx.InstrD[11:8], 1'b0};
            2'b11: w_imm = {{12{dx.InstrD[31]}}, dx.InstrD[19:12],
                            dx.InstrD[20], dx.InstrD[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    // Out-of-range destinations (RV32E) are dropped here, so bypass never sees them
    assign w_we = dx.RegWriteW && (dx.RDW != 5'd0) && ({1'b0, dx.RDW} < NR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < NREGS; k++) r_regs[k] <= '0;
        end else if (w_we) begin
            for (int k = 1; k < NREGS; k++) begin
                if (dx.RDW == 5'(k)) r_regs[k] <= dx.ResultW;
            end
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        for (int k = 1; k < NREGS; k++) begin
            if (w_rs1 == 5'(k)) w_rd1 = r_regs[k];
            if (w_rs2 == 5'(k)) w_rd2 = r_regs[k];
        end
        if (BYPASS != 0) begin
            if (w_we && (dx.RDW == w_rs1)) w_rd1 = dx.ResultW;
            if (w_we && (dx.RDW == w_rs2)) w_rd2 = dx.ResultW;
        end
    end

    assign w_use1 = !((w_op == OP_JAL) || (w_op == OP_LUI) ||
                      (w_op == OP_AUIPC));
    assign w_use2 = w_is_r | w_is_st | w_is_br;

    assign w_lu = dx.ValidD & r_e.valid & r_e.regwrite & r_e.resultsrc &
                  (r_e.rd != 5'd0) &
                  ((w_use1 & (r_e.rd == w_rs1)) |
                   (w_use2 & (r_e.rd == w_rs2)));

    always_comb begin
        w_dec           = '0;
        w_dec.valid     = dx.ValidD;
        w_dec.regwrite  = dx.ValidD & w_regwrite;
        w_dec.alusrc    = dx.ValidD & w_alusrc;
        w_dec.memwrite  = dx.ValidD & w_memwrite;
        w_dec.resultsrc = dx.ValidD & w_resultsrc;
        w_dec.branch    = dx.ValidD & w_branch;
        w_dec.jump      = dx.ValidD & w_jump;
        w_dec.aluctl    = dx.ValidD ? w_aluctl : 3'b000;
        w_dec.rd1       = w_rd1;
        w_dec.rd2       = w_rd2;
        w_dec.imm       = w_imm;
        w_dec.pc        = dx.PCD;
        w_dec.pc4       = dx.PCPlus4D;
        w_dec.rs1       = w_rs1;
        w_dec.rs2       = w_rs2;
        w_dec.rd        = w_rd;
        w_dec.illegal   = dx.ValidD & (({1'b0, w_rs1} >= NR) |
                                       ({1'b0, w_rs2} >= NR) |
                                       ({1'b0, w_rd}  >= NR));
    end

    // Flush outranks stall, stall outranks the hazard bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e    <= '0;
            r_bcnt <= '0;
        end else if (dx.FlushE) begin
            r_e <= '0;
        end else if (!dx.StallE) begin
            if (w_lu) begin
                r_e <= '0;
                if (r_bcnt != '1) r_bcnt <= r_bcnt + CNT_W'(1);
            end else begin
                r_e <= w_dec;
            end
        end
    end

    assign dx.LoadUseD    = w_lu;
    assign dx.ValidE      = r_e.valid;
    assign dx.RegWriteE   = r_e.regwrite;
    assign dx.ALUSrcE     = r_e.alusrc;
    assign dx.MemWriteE   = r_e.memwrite;
    assign dx.ResultSrcE  = r_e.resultsrc;
    assign dx.BranchE     = r_e.branch;
    assign dx.JumpE       = r_e.jump;
    assign dx.ALUControlE = r_e.aluctl;
    assign dx.RD1_E       = r_e.rd1;
    assign dx.RD2_E       = r_e.rd2;
    assign dx.Imm_Ext_E   = r_e.imm;
    assign dx.PCE         = r_e.pc;
    assign dx.PCPlus4E    = r_e.pc4;
    assign dx.RS1_E       = r_e.rs1;
    assign dx.RS2_E       = r_e.rs2;
    assign dx.RD_E        = r_e.rd;
    assign dx.IllegalE    = r_e.illegal;
    assign dx.BubbleCnt   = r_bcnt;

endmodule

// File: tb/tb_decode_stage_hz.sv
// Scoreboard bench: RV32I/bypass and RV32E/no-bypass/2-bit-counter decoders share stimulus.
module tb_decode_stage_hz;

    typedef struct packed {
        logic        lu;
        logic        valid;
        logic        illegal;
        logic [8:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [14:0] idx;
        logic [15:0] bcnt;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    decode_stage_hz_if #(.CNT_W(16)) if0 ();
    decode_stage_hz_if #(.CNT_W(2))  if1 ();

    decode_stage_hz #(.NREGS(32), .BYPASS(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .dx(if0)
    );
    decode_stage_hz #(.NREGS(16), .BYPASS(0), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .dx(if1)
    );

    int nr_m   [2] = '{32, 16};
    int byp_m  [2] = '{1, 0};
    int bmax_m [2] = '{65535, 3};

    logic [31:0] mreg [2][32];
    exp_t        me [2];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;

    logic [31:0] c_ins, c_res, c_pc;
    logic        c_vd, c_st, c_fl, c_rw;
    logic [4:0]  c_rdw;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] i_r(logic [4:0] rd, logic [4:0] rs1,
                                        logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_lw(logic [4:0] rd, logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [2:0] m_alu(logic [31:0] ins, logic isr);
        case (ins[14:12])
            3'b000:  return (isr && ins[30]) ? 3'd1 : 3'd0;
            3'b010:  return 3'd5;
            3'b110:  return 3'd3;
            3'b111:  return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    // {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ALUControl}
    function automatic logic [8:0] m_ctrl(logic [31:0] ins);
        case (ins[6:0])
            7'b0000011: return {6'b110100, 3'd0};
            7'b0100011: return {6'b011000, 3'd0};
            7'b0110011: return {6'b100000, m_alu(ins, 1'b1)};
            7'b0010011: return {6'b110000, m_alu(ins, 1'b0)};
            7'b1100011: return {6'b000010, 3'd1};
            7'b1101111: return {6'b100001, 3'd0};
            default:    return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_imm(logic [31:0] ins);
        case (ins[6:0])
            7'b0100011: return 32'($signed({ins[31:25], ins[11:7]}));
            7'b1100011: return 32'($signed({ins[31], ins[7], ins[30:25],
                                            ins[11:8], 1'b0}));
            7'b1101111: return 32'($signed({ins[31], ins[19:12], ins[20],
                                            ins[30:21], 1'b0}));
            default:    return 32'($signed(ins[31:20]));
        endcase
    endfunction

    function automatic logic [31:0] m_read(int d, logic [4:0] a);
        if (a == 5'd0 || int'(a) >= nr_m[d]) return 32'd0;
        if (byp_m[d] != 0 && c_rw && c_rdw == a) return c_res;
        return mreg[d][a];
    endfunction

    function automatic logic m_lu(int d);
        logic [6:0] op;
        logic [4:0] erd;
        logic       u1, u2;
        op  = c_ins[6:0];
        erd = me[d].idx[4:0];
        u1  = !(op inside {7'b1101111, 7'b0110111, 7'b0010111});
        u2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return c_vd && me[d].valid && me[d].ctrl[8] && me[d].ctrl[5] &&
               erd != 5'd0 &&
               ((u1 && erd == c_ins[19:15]) || (u2 && erd == c_ins[24:20]));
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            me[d] = '0;
            for (int k = 0; k < 32; k++) mreg[d][k] = 32'd0;
        end
    endtask

    task automatic m_step(int d);
        exp_t nx;
        logic lu;
        lu = m_lu(d);
        nx = '0;
        nx.bcnt = me[d].bcnt;
        if (c_fl) begin
            nx = nx;
        end else if (c_st) begin
            nx = me[d];
        end else if (lu) begin
            if (int'(me[d].bcnt) < bmax_m[d]) nx.bcnt = me[d].bcnt + 16'd1;
        end else begin
            nx.valid   = c_vd;
            nx.ctrl    = c_vd ? m_ctrl(c_ins) : 9'd0;
            nx.rd1     = m_read(d, c_ins[19:15]);
            nx.rd2     = m_read(d, c_ins[24:20]);
            nx.imm     = m_imm(c_ins);
            nx.pc      = c_pc;
            nx.pc4     = c_pc + 32'd4;
            nx.idx     = {c_ins[19:15], c_ins[24:20], c_ins[11:7]};
            nx.illegal = c_vd && (int'(c_ins[19:15]) >= nr_m[d] ||
                                  int'(c_ins[24:20]) >= nr_m[d] ||
                                  int'(c_ins[11:7])  >= nr_m[d]);
        end
        nx.lu = 1'b0;
        if (c_rw && c_rdw != 5'd0 && int'(c_rdw) < nr_m[d])
            mreg[d][c_rdw] = c_res;
        me[d] = nx;
    endtask

    task automatic drive(input logic [31:0] ins, input logic vd, input logic st,
                         input logic fl, input logic rw, input logic [4:0] rdw,
                         input logic [31:0] res);
        c_ins = ins; c_vd = vd; c_st = st; c_fl = fl;
        c_rw = rw; c_rdw = rdw; c_res = res; c_pc = $urandom() & ~32'd3;
        if0.InstrD = ins; if0.ValidD = vd; if0.StallE = st; if0.FlushE = fl;
        if0.RegWriteW = rw; if0.RDW = rdw; if0.ResultW = res;
        if0.PCD = c_pc; if0.PCPlus4D = c_pc + 32'd4;
        if1.InstrD = ins; if1.ValidD = vd; if1.StallE = st; if1.FlushE = fl;
        if1.RegWriteW = rw; if1.RDW = rdw; if1.ResultW = res;
        if1.PCD = c_pc; if1.PCPlus4D = c_pc + 32'd4;
    endtask

    task automatic push();
        exp_t r;
        cyc++;
        r = me[0]; r.lu = m_lu(0); q0.push_back(r);
        r = me[1]; r.lu = m_lu(1); q1.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_step(0);
            m_step(1);
        end
        #2;
    endtask

    task automatic cycle(input logic [31:0] ins, input logic vd, input logic st,
                         input logic fl, input logic rw, input logic [4:0] rdw,
                         input logic [31:0] res);
        tick();
        drive(ins, vd, st, fl, rw, rdw, res);
        push();
    endtask

    function automatic logic [4:0] rand_idx();
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(16, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_ins();
        logic [31:0] v;
        v = $urandom();
        case ($urandom_range(0, 8))
            0, 1:    v[6:0] = 7'b0000011;
            2:       v[6:0] = 7'b0100011;
            3, 4:    v[6:0] = 7'b0110011;
            5:       v[6:0] = 7'b1100011;
            6:       v[6:0] = 7'b0010011;
            7:       v[6:0] = ($urandom_range(0, 2) == 0) ? 7'b1101111 :
                              ($urandom_range(0, 1) == 0) ? 7'b0110111 :
                                                            7'b0010111;
            default: v[6:0] = 7'($urandom());
        endcase
        v[11:7]  = rand_idx();
        v[19:15] = rand_idx();
        v[24:20] = rand_idx();
        return v;
    endfunction

    task automatic rand_cycles(int n);
        for (int i = 0; i < n; i++) begin
            cycle(rand_ins(), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                  1'($urandom_range(0, 1)), rand_idx(), $urandom());
        end
    endtask

    function automatic exp_t grab(int d);
        exp_t r;
        r = '0;
        if (d == 0) begin
            r.lu = if0.LoadUseD; r.valid = if0.ValidE; r.illegal = if0.IllegalE;
            r.ctrl = {if0.RegWriteE, if0.ALUSrcE, if0.MemWriteE, if0.ResultSrcE,
                      if0.BranchE, if0.JumpE, if0.ALUControlE};
            r.rd1 = if0.RD1_E; r.rd2 = if0.RD2_E; r.imm = if0.Imm_Ext_E;
            r.pc = if0.PCE; r.pc4 = if0.PCPlus4E;
            r.idx = {if0.RS1_E, if0.RS2_E, if0.RD_E};
            r.bcnt = if0.BubbleCnt;
        end else begin
            r.lu = if1.LoadUseD; r.valid = if1.ValidE; r.illegal = if1.IllegalE;
            r.ctrl = {if1.RegWriteE, if1.ALUSrcE, if1.MemWriteE, if1.ResultSrcE,
                      if1.BranchE, if1.JumpE, if1.ALUControlE};
            r.rd1 = if1.RD1_E; r.rd2 = if1.RD2_E; r.imm = if1.Imm_Ext_E;
            r.pc = if1.PCE; r.pc4 = if1.PCPlus4E;
            r.idx = {if1.RS1_E, if1.RS2_E, if1.RD_E};
            r.bcnt = {14'd0, if1.BubbleCnt};
        end
        return r;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] a,
                         input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s dut%0d cyc%0d: got %h expected %h",
                      nm, d, cyc, a, e);
    endtask

    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ((d == 0 ? q0.size() : q1.size()) > 0) begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    a = grab(d);
                    check("LoadUseD", d, 32'(a.lu), 32'(e.lu));
                    check("ValidE", d, 32'(a.valid), 32'(e.valid));
                    check("IllegalE", d, 32'(a.illegal), 32'(e.illegal));
                    check("ctrl", d, 32'(a.ctrl), 32'(e.ctrl));
                    check("RD1_E", d, a.rd1, e.rd1);
                    check("RD2_E", d, a.rd2, e.rd2);
                    check("Imm_Ext_E", d, a.imm, e.imm);
                    check("PCE", d, a.pc, e.pc);
                    check("PCPlus4E", d, a.pc4, e.pc4);
                    check("regidx", d, 32'(a.idx), 32'(e.idx));
                    check("BubbleCnt", d, 32'(a.bcnt), 32'(e.bcnt));
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        m_reset();
        drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #2;
        push();
        tick();
        rst = 1'b1;
        drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        push();

        cycle(NOP, 0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        cycle(i_r(7, 5, 0), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(8, 3, 0), 1, 0, 0, 1, 5'd3, 32'h1234_5678);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);

        cycle(i_lw(4, 1), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 4, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 4, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_lw(0, 1), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 0, 4), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);

        cycle(i_lw(4, 1), 1, 0, 0, 0, 5'd0, 32'd0);
        repeat (3) cycle(i_r(6, 4, 2), 1, 1, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 4, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 4, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);

        cycle(i_lw(4, 1), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(i_r(6, 4, 2), 1, 0, 1, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 1, 5'd0, 32'hFFFF_FFFF);
        cycle(i_r(9, 0, 0), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);

        cycle(i_r(17, 1, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 1, 5'd20, 32'hAAAA_5555);
        cycle(i_r(1, 20, 20), 1, 0, 0, 0, 5'd0, 32'd0);
        cycle(NOP, 0, 0, 0, 0, 5'd0, 32'd0);

        repeat (5) begin
            cycle(i_lw(4, 1), 1, 0, 0, 0, 5'd0, 32'd0);
            cycle(i_r(6, 4, 2), 1, 0, 0, 0, 5'd0, 32'd0);
        end

        rand_cycles(600);

        tick();
        rst = 1'b0;
        m_reset();
        drive(i_r(6, 4, 2), 1, 0, 0, 1, 5'd4, $urandom());
        push();
        tick();
        rst = 1'b1;
        drive(NOP, 0, 0, 0, 0, 5'd0, 32'd0);
        push();

        rand_cycles(300);

        @(negedge clk);
        #1;
        check("queue_drain", 0, 32'(q0.size() + q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
